// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU decode-stage interlock.
package cpu_pkg;

    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int CNTW = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hazState_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down scoreboard counter: one increment, two decrements per cycle.
// A net decrement below zero holds the counter at zero and raises underflow.
module sb_counter #(
    parameter int CNTW = cpu_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            decA,
    input  logic            decB,
    output logic [CNTW-1:0] count,
    output logic            underflow
);

    logic [CNTW+1:0] sum;
    logic [CNTW-1:0] nextCount;

    // NOTE: every variable written here gets a value first, so no latch is inferred.
    always_comb begin
        sum = {2'b00, count}
            + {{(CNTW+1){1'b0}}, inc}
            - {{(CNTW+1){1'b0}}, decA}
            - {{(CNTW+1){1'b0}}, decB};
        underflow = sum[CNTW+1];
        if (sum[CNTW+1]) begin
            nextCount = '0;
        end else if (sum[CNTW]) begin
            nextCount = '1;
        end else begin
            nextCount = sum[CNTW-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= nextCount;
        end
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage scoreboard: RAW interlock, write-count saturation stall and HLT drain.
// Build option DECODE_BYPASS_EN: only outstanding loads create a RAW hazard.
module decode_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int NREG = cpu_pkg::NREG,
    parameter int AW   = cpu_pkg::AW,
    parameter int CNTW = cpu_pkg::CNTW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_src1,
    input  logic          id_src1_used,
    input  logic [AW-1:0] id_src2,
    input  logic          id_src2_used,
    input  logic [AW-1:0] id_dst,
    input  logic          id_wr,
    input  logic          id_load,
    input  logic          id_halt,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_dst,
    input  logic          wb_load,
    input  logic          kill_valid,
    input  logic [AW-1:0] kill_dst,
    input  logic          kill_load,
    output logic          stall,
    output logic          issue,
    output logic          halted,
    output logic          err
);

    logic [NREG-1:0][CNTW-1:0] cnt;
    logic [NREG-1:0][CNTW-1:0] lcnt;
    logic [NREG-1:0]           cntUnder;
    logic [NREG-1:0]           lcntUnder;
    logic [NREG-1:0]           pendVec;

    hazState_t state;
    hazState_t nextState;

    logic hazard;
    logic full;
    logic allIdle;

    // R0 is hardwired zero, so it never owns a counter and never looks pending.
    assign cnt[0]       = '0;
    assign lcnt[0]      = '0;
    assign cntUnder[0]  = 1'b0;
    assign lcntUnder[0] = 1'b0;
    assign pendVec[0]   = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic hitId;
        logic hitWb;
        logic hitKill;

        assign hitId   = issue & id_wr & (id_dst == AW'(r));
        assign hitWb   = wb_valid & (wb_dst == AW'(r));
        assign hitKill = kill_valid & (kill_dst == AW'(r));

        sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (hitId),
            .decA      (hitWb),
            .decB      (hitKill),
            .count     (cnt[r]),
            .underflow (cntUnder[r])
        );

        sb_counter #(.CNTW(CNTW)) u_lcnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (hitId & id_load),
            .decA      (hitWb & wb_load),
            .decB      (hitKill & kill_load),
            .count     (lcnt[r]),
            .underflow (lcntUnder[r])
        );

`ifdef DECODE_BYPASS_EN
        assign pendVec[r] = |lcnt[r];
`else
        assign pendVec[r] = |cnt[r];
`endif
    end

    // Registered counts only: a retire in this cycle releases the stall next cycle.
    assign hazard  = (id_src1_used & (id_src1 != '0) & pendVec[id_src1])
                   | (id_src2_used & (id_src2 != '0) & pendVec[id_src2]);
    assign full    = id_wr & (id_dst != '0) & (&cnt[id_dst]);
    assign allIdle = ~|cnt;

    assign stall  = id_valid & ((state != RUN) | hazard | full);
    assign issue  = id_valid & ~stall;
    assign halted = (state == HALTED);

    always_comb begin
        nextState = state;
        unique case (state)
            RUN:     if (issue && id_halt) nextState = DRAIN;
            DRAIN:   if (allIdle)          nextState = HALTED;
            HALTED:  nextState = HALTED;
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            err   <= 1'b0;
        end else begin
            state <= nextState;
            if (|cntUnder || |lcntUnder) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl with a per-register outstanding-write model
// compared on every falling edge, plus hand-computed spot checks.
module tb_decode_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0, id_src1_used = 1'b0, id_src2_used = 1'b0;
    logic       id_wr = 1'b0, id_load = 1'b0, id_halt = 1'b0;
    logic [3:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
    logic       wb_valid = 1'b0, wb_load = 1'b0, kill_valid = 1'b0, kill_load = 1'b0;
    logic [3:0] wb_dst = '0, kill_dst = '0;
    logic       stall, issue, halted, err;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    decode_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src1_used (id_src1_used),
        .id_src2      (id_src2),
        .id_src2_used (id_src2_used),
        .id_dst       (id_dst),
        .id_wr        (id_wr),
        .id_load      (id_load),
        .id_halt      (id_halt),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .wb_load      (wb_load),
        .kill_valid   (kill_valid),
        .kill_dst     (kill_dst),
        .kill_load    (kill_load),
        .stall        (stall),
        .issue        (issue),
        .halted       (halted),
        .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outstanding writes per register; 0=run, 1=drain, 2=halted.
    int mCnt[16];
    int mLcnt[16];
    int mState = 0;
    bit mErr = 1'b0;

    function automatic bit pendM(input int r);
        if (r == 0) return 1'b0;
`ifdef DECODE_BYPASS_EN
        return mLcnt[r] != 0;
`else
        return mCnt[r] != 0;
`endif
    endfunction

    function automatic bit expStall();
        bit haz, fullW;
        haz   = (id_src1_used && pendM(int'(id_src1))) || (id_src2_used && pendM(int'(id_src2)));
        fullW = id_wr && (id_dst != 0) && (mCnt[id_dst] == 3);
        return id_valid && (mState != 0 || haz || fullW);
    endfunction

    function automatic int deltaFor(input int r, input bit loadOnly);
        int d;
        d = 0;
        if (id_valid && !expStall() && id_wr && id_dst == r && (!loadOnly || id_load)) d++;
        if (wb_valid && wb_dst == r && (!loadOnly || wb_load)) d--;
        if (kill_valid && kill_dst == r && (!loadOnly || kill_load)) d--;
        return d;
    endfunction

    function automatic int clampNext(input int cur, input int d);
        int v;
        v = cur + d;
        if (v < 0) v = 0;
        if (v > 3) v = 3;
        return v;
    endfunction

    function automatic bit anyUnderflow();
        for (int r = 1; r < 16; r++) begin
            if (mCnt[r] + deltaFor(r, 1'b0) < 0) return 1'b1;
            if (mLcnt[r] + deltaFor(r, 1'b1) < 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit allZero();
        for (int r = 1; r < 16; r++) if (mCnt[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 16; r++) begin
                mCnt[r]  <= 0;
                mLcnt[r] <= 0;
            end
            mState <= 0;
            mErr   <= 1'b0;
        end else begin
            for (int r = 1; r < 16; r++) begin
                mCnt[r]  <= clampNext(mCnt[r], deltaFor(r, 1'b0));
                mLcnt[r] <= clampNext(mLcnt[r], deltaFor(r, 1'b1));
            end
            if (anyUnderflow()) mErr <= 1'b1;
            if (mState == 0 && id_valid && !expStall() && id_halt) mState <= 1;
            else if (mState == 1 && allZero()) mState <= 2;
        end
    end

    always @(negedge clk) begin
        check("stall", stall, expStall());
        check("issue", issue, id_valid && !expStall());
        check("halted", halted, mState == 2);
        check("err", err, mErr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s1, input logic s1u,
                         input logic [3:0] s2, input logic s2u, input logic [3:0] d,
                         input logic wr, input logic ld, input logic hlt);
        id_valid = v; id_src1 = s1; id_src1_used = s1u; id_src2 = s2; id_src2_used = s2u;
        id_dst = d; id_wr = wr; id_load = ld; id_halt = hlt;
        #1;
    endtask

    task automatic retire(input logic wv, input logic [3:0] wd, input logic wl,
                          input logic kv, input logic [3:0] kd, input logic kl);
        wb_valid = wv; wb_dst = wd; wb_load = wl;
        kill_valid = kv; kill_dst = kd; kill_load = kl;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        retire(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        repeat (2) tick();
        check("reset stall", stall, 0);
        check("reset issue", issue, 0);
        check("reset halted", halted, 0);
        check("reset err", err, 0);
        rst = 1'b1;
        tick();

`ifndef DECODE_BYPASS_EN
        // ADD R3 <- R1 ; SUB R4 <- R3 waits for R3's writeback
        drive(1, 1, 1, 2, 0, 3, 1, 0, 0);
        check("t1 add issue", issue, 1);
        tick();
        drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
        check("t1 raw stall", stall, 1);
        tick();
        check("t1 raw stall hold", stall, 1);
        retire(1, 3, 0, 0, 0, 0);
        check("t1 no write-through", stall, 1);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        check("t1 release issue", issue, 1);
        tick();
        idle();
        retire(1, 4, 0, 0, 0, 0);
        tick();
        idle();
`else
        // ALU result is bypassed; a load result is not
        drive(1, 1, 1, 0, 0, 3, 1, 0, 0);
        check("t2 add issue", issue, 1);
        tick();
        drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
        check("t2 bypass no stall", stall, 0);
        tick();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0);
        retire(1, 3, 0, 0, 0, 0);
        check("t2 lw issue", issue, 1);
        tick();
        drive(1, 4, 1, 0, 0, 5, 1, 0, 0);
        retire(1, 4, 0, 0, 0, 0);
        check("t2 load-use stall", stall, 1);
        tick();
        retire(1, 4, 1, 0, 0, 0);
        check("t2 load-use hold", stall, 1);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        check("t2 load-use release", issue, 1);
        tick();
        idle();
        retire(1, 5, 0, 0, 0, 0);
        tick();
        idle();
`endif

        // Three writers to R5 fill its counter; the fourth stalls
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
            check("t3 writer issue", issue, 1);
            tick();
        end
        check("t3 full stall", stall, 1);
        tick();
        retire(1, 5, 0, 0, 0, 0);
        check("t3 full hold", stall, 1);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        check("t3 full release", issue, 1);
        tick();
        idle();
        retire(1, 5, 0, 1, 5, 0);
        tick();
        retire(1, 5, 0, 0, 0, 0);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
        check("t3 drained reader", issue, 1);
        check("t3 no err", err, 0);
        tick();
        idle();

        // R0 on every field: never stalls, never tracked
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 1, 0, 1, 1, 0);
            check("t4 r0 issue", issue, 1);
            tick();
        end
        idle();
        retire(1, 0, 1, 1, 0, 1);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        check("t4 r0 retire no err", err, 0);

        // HLT with R2 and R7 pending drains before halting
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t5 hlt issue", issue, 1);
        tick();
        drive(1, 1, 1, 0, 0, 3, 1, 0, 0);
        check("t5 drain stall", stall, 1);
        retire(1, 2, 0, 0, 0, 0);
        tick();
        retire(1, 7, 1, 0, 0, 0);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        check("t5 drained not yet halted", halted, 0);
        tick();
        check("t5 halted", halted, 1);
        check("t5 halted stall", stall, 1);
        repeat (3) tick();
        check("t5 halted sticky", halted, 1);
        idle();

        // Reset clears halted; kill against an empty counter flags err
        rst = 1'b0;
        #1;
        check("t6 reset halted", halted, 0);
        rst = 1'b1;
        tick();
        retire(0, 0, 0, 1, 6, 0);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        check("t6 kill underflow err", err, 1);
        tick();
        check("t6 err sticky", err, 1);

        // Reset in the middle of a drain
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 2, 1, 7, 1, 2, 1, 0, 0);
        check("t6 drain stall", stall, 1);
        rst = 1'b0;
        #1;
        check("t6 reset err clear", err, 0);
        check("t6 reset not halted", halted, 0);
        rst = 1'b1;
        #1;
        check("t6 counters cleared", issue, 1);
        tick();
        idle();
        retire(0, 0, 0, 1, 7, 0);
        tick();
        retire(0, 0, 0, 0, 0, 0);
        check("t6 stale kill err", err, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
